// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-commit store buffer: entry layout, drain FSM states,
// and the word-granular address compare used for load conflict detection.
package store_commit_buffer_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wmask;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_WRITE,
        SB_GAP
    } sb_state_t;

    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/store_commit_buffer.sv
// In-order buffer of committed stores draining to the d-cache write port, with a
// parallel word-address match over all pending entries for load stall decisions.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [31:0]              enq_addr_i,
    input  logic [31:0]              enq_data_i,
    input  logic [3:0]               enq_wmask_i,
    input  logic                     dmem_hold_i,
    output logic                     dmem_write_o,
    output logic [31:0]              dmem_address_o,
    output logic [31:0]              dmem_wdata_o,
    output logic [3:0]               dmem_wmask_o,
    input  logic                     dmem_resp_i,
    input  logic [31:0]              ld_check_addr_i,
    output logic                     ld_conflict_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    sb_entry_t        head_e;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    sb_state_t        state, state_nx;
    logic             full, enq, deq;
    logic             unused_low_bits;

    assign full  = (count == CNT_W'(DEPTH));
    assign enq   = enq_valid_i & ~full;
    assign deq   = (state == SB_WRITE) & dmem_resp_i;

    // Payload storage carries no reset; outputs are gated by count instead.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            entries[tail] <= '{addr: enq_addr_i, data: enq_data_i, wmask: enq_wmask_i};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= SB_IDLE;
        end else begin
            state <= state_nx;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SB_IDLE:  if (count != '0 && !dmem_hold_i) state_nx = SB_WRITE;
            SB_WRITE: if (dmem_resp_i) state_nx = SB_GAP;
            SB_GAP:   state_nx = (count != '0 && !dmem_hold_i) ? SB_WRITE : SB_IDLE;
            default:  state_nx = SB_IDLE;
        endcase
    end

    always_comb begin
        ld_conflict_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && word_match(entries[i].addr, ld_check_addr_i)) begin
                ld_conflict_o = 1'b1;
            end
        end
    end

    always_comb begin
        head_e         = entries[head];
        dmem_address_o = '0;
        dmem_wdata_o   = '0;
        dmem_wmask_o   = '0;
        if (count != '0) begin
            dmem_address_o = {head_e.addr[31:2], 2'b00};
            dmem_wdata_o   = head_e.data;
            dmem_wmask_o   = head_e.wmask;
        end
    end

    assign unused_low_bits = ^{ld_check_addr_i[1:0], head_e.addr[1:0]};

    assign enq_ready_o  = ~full;
    assign dmem_write_o = (state == SB_WRITE);
    assign empty_o      = (count == '0) && (state == SB_IDLE);
    assign count_o      = count;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: a per-cycle vector table for single-store,
// conflict and hold behaviour, plus hand sequences for fill, streaming wrap and reset.
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enq_valid, enq_ready;
    logic [31:0] enq_addr, enq_data;
    logic [3:0]  enq_wmask;
    logic        dmem_hold, dmem_write, dmem_resp;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] ld_check_addr;
    logic        ld_conflict, empty;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_commit_buffer #(.DEPTH(8)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .enq_valid_i     (enq_valid),
        .enq_ready_o     (enq_ready),
        .enq_addr_i      (enq_addr),
        .enq_data_i      (enq_data),
        .enq_wmask_i     (enq_wmask),
        .dmem_hold_i     (dmem_hold),
        .dmem_write_o    (dmem_write),
        .dmem_address_o  (dmem_address),
        .dmem_wdata_o    (dmem_wdata),
        .dmem_wmask_o    (dmem_wmask),
        .dmem_resp_i     (dmem_resp),
        .ld_check_addr_i (ld_check_addr),
        .ld_conflict_o   (ld_conflict),
        .empty_o         (empty),
        .count_o         (count)
    );

    typedef struct {
        logic        enq;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        hold;
        logic        resp;
        logic [31:0] ld;
        logic        e_write;
        logic        e_ready;
        logic [3:0]  e_count;
        logic        e_conf;
        logic        e_empty;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_t;

    vec_t tbl[$];
    st_t  sq[$];

    function automatic vec_t mk(input logic enq, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] mask, input logic hold, input logic resp,
                                input logic [31:0] ld, input logic e_write, input logic e_ready,
                                input logic [3:0] e_count, input logic e_conf, input logic e_empty,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [3:0] e_wmask);
        vec_t v;
        v.enq = enq; v.addr = addr; v.data = data; v.mask = mask;
        v.hold = hold; v.resp = resp; v.ld = ld;
        v.e_write = e_write; v.e_ready = e_ready; v.e_count = e_count; v.e_conf = e_conf;
        v.e_empty = e_empty; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wmask = e_wmask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_write(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dmem_write === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: dmem_write never rose within 20 cycles", name);
        end
    endtask

    task automatic push_enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_t s;
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_wmask = m;
        s.addr = a; s.data = d; s.mask = m;
        sq.push_back(s);
    endtask

    task automatic chk_head(input string name);
        chk({name, "_addr"},  dmem_address, sq[0].addr);
        chk({name, "_wdata"}, dmem_wdata,   sq[0].data);
        chk({name, "_wmask"}, 32'(dmem_wmask), 32'(sq[0].mask));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_wmask = '0;
        dmem_hold = 1'b0; dmem_resp = 1'b0; ld_check_addr = 32'h60;

        #1;
        chk("rst_ready", 32'(enq_ready), 32'd1);
        chk("rst_write", 32'(dmem_write), 32'd0);
        chk("rst_conf",  32'(ld_conflict), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr",  dmem_address, 32'd0);

        // Single store, then conflict and hold behaviour in IDLE and WRITE.
        tbl.push_back(mk(1, 32'h60, 32'hDEADBEEF, 4'hF, 0, 0, 32'h60, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h60, 0, 1, 1, 1, 0, 32'h60, 32'hDEADBEEF, 4'hF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h60, 1, 1, 1, 1, 0, 32'h60, 32'hDEADBEEF, 4'hF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h60, 1, 1, 1, 1, 0, 32'h60, 32'hDEADBEEF, 4'hF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h60, 1, 1, 1, 1, 0, 32'h60, 32'hDEADBEEF, 4'hF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h60, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h60, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h104, 32'h11111111, 4'h3, 1, 0, 32'h106, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h200, 32'h22222222, 4'hC, 1, 0, 32'h106, 0, 1, 1, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h108, 0, 1, 2, 0, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h106, 0, 1, 2, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h106, 0, 1, 2, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h106, 1, 1, 2, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h106, 1, 1, 2, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h106, 1, 1, 2, 1, 0, 32'h104, 32'h11111111, 4'h3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h106, 0, 1, 1, 0, 0, 32'h200, 32'h22222222, 4'hC));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h200, 0, 1, 1, 1, 0, 32'h200, 32'h22222222, 4'hC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h200, 0, 1, 1, 1, 0, 32'h200, 32'h22222222, 4'hC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h200, 1, 1, 1, 1, 0, 32'h200, 32'h22222222, 4'hC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h200, 0, 1, 0, 0, 1, 0, 0, 0));

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            enq_valid = tbl[i].enq; enq_addr = tbl[i].addr; enq_data = tbl[i].data;
            enq_wmask = tbl[i].mask; dmem_hold = tbl[i].hold; dmem_resp = tbl[i].resp;
            ld_check_addr = tbl[i].ld;
            #1;
            chk($sformatf("v%0d_write", i), 32'(dmem_write),  32'(tbl[i].e_write));
            chk($sformatf("v%0d_ready", i), 32'(enq_ready),   32'(tbl[i].e_ready));
            chk($sformatf("v%0d_count", i), 32'(count),       32'(tbl[i].e_count));
            chk($sformatf("v%0d_conf",  i), 32'(ld_conflict), 32'(tbl[i].e_conf));
            chk($sformatf("v%0d_empty", i), 32'(empty),       32'(tbl[i].e_empty));
            chk($sformatf("v%0d_addr",  i), dmem_address,     tbl[i].e_addr);
            chk($sformatf("v%0d_wdata", i), dmem_wdata,       tbl[i].e_wdata);
            chk($sformatf("v%0d_wmask", i), 32'(dmem_wmask),  32'(tbl[i].e_wmask));
            @(negedge clk);
        end
        enq_valid = 1'b0; dmem_resp = 1'b0; dmem_hold = 1'b0;

        // Fill to DEPTH under hold, reject a 9th, then drain in order with one GAP each.
        dmem_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_enq(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'(i + 1));
            @(negedge clk);
        end
        enq_valid = 1'b1; enq_addr = 32'h9990; enq_data = 32'h99; enq_wmask = 4'hF;
        ld_check_addr = 32'h9990;
        #1;
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ready", 32'(enq_ready), 32'd0);
        @(negedge clk); #1;
        chk("fill_9th_count", 32'(count), 32'd8);
        chk("fill_9th_conf", 32'(ld_conflict), 32'd0);
        enq_valid = 1'b0;
        @(negedge clk);
        dmem_hold = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            wait_write($sformatf("drain%0d_wait", k));
            chk_head($sformatf("drain%0d", k));
            if (k == 0) begin
                enq_valid = 1'b1;
                #1;
                chk("full_deq_ready", 32'(enq_ready), 32'd0);
            end
            dmem_resp = 1'b1;
            @(negedge clk);
            dmem_resp = 1'b0; enq_valid = 1'b0;
            #1;
            chk($sformatf("drain%0d_gap", k), 32'(dmem_write), 32'd0);
            chk($sformatf("drain%0d_count", k), 32'(count), 32'(7 - k));
            void'(sq.pop_front());
            @(negedge clk); #1;
            if (k < 7) chk($sformatf("drain%0d_rewrite", k), 32'(dmem_write), 32'd1);
            else       chk("drain_empty", 32'(empty), 32'd1);
        end

        // Steady-state enqueue alongside resp at count=3; pointers wrap repeatedly.
        dmem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_enq(32'h2000 + 32'(4 * i), 32'hB0000000 + 32'(i), 4'(i + 2));
            @(negedge clk);
        end
        enq_valid = 1'b0; dmem_hold = 1'b0;
        #1;
        for (int r = 0; r < 10; r++) begin
            wait_write($sformatf("stream%0d_wait", r));
            chk_head($sformatf("stream%0d", r));
            dmem_resp = 1'b1;
            push_enq(32'h2000 + 32'(4 * (r + 3)), 32'hB0000000 + 32'(r + 3), 4'(r + 5));
            @(negedge clk);
            dmem_resp = 1'b0; enq_valid = 1'b0;
            #1;
            chk($sformatf("stream%0d_count", r), 32'(count), 32'd3);
            void'(sq.pop_front());
        end
        for (int r = 0; r < 3; r++) begin
            wait_write($sformatf("tail%0d_wait", r));
            chk_head($sformatf("tail%0d", r));
            dmem_resp = 1'b1;
            @(negedge clk);
            dmem_resp = 1'b0;
            #1;
            chk($sformatf("tail%0d_count", r), 32'(count), 32'(2 - r));
            void'(sq.pop_front());
        end

        // Asynchronous reset between edges while a write is outstanding.
        @(negedge clk);
        push_enq(32'h3000, 32'hC0FFEE00, 4'h5);
        @(negedge clk);
        enq_valid = 1'b0;
        #1;
        wait_write("areset_wait");
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("areset_write", 32'(dmem_write), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_ready", 32'(enq_ready), 32'd1);
        chk("areset_addr",  dmem_address, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        chk("stale_resp_count", 32'(count), 32'd0);
        chk("stale_resp_write", 32'(dmem_write), 32'd0);
        chk("stale_resp_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
